// File: rtl/cdb_age_arbiter.sv
`default_nettype none
// ============================================================================
// cdb_age_arbiter
// Common-data-bus write-port arbiter: max-priority unit first, round-robin
// stations, saturating age counter bounds station wait, winner held until taken.
// Revision: 1.0
// ============================================================================
module cdb_age_arbiter #(
  parameter int N_REQ      = 7,
  parameter int STARVE_MAX = 4,
  parameter int SEL_W      = $clog2(N_REQ + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             max_prio_valid_i,
  output logic             max_prio_ready_o,
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] ready_o,
  input  logic             rob_ready_i,
  output logic             rob_valid_o,
  output logic             served_max_prio_o,
  output logic [SEL_W-1:0] served_o
);

  localparam int               c_PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]       c_STARVE_MAX = 4'(STARVE_MAX);
  localparam logic [SEL_W-1:0] c_SEL_LAST   = SEL_W'(N_REQ);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t        r_state, w_state_nxt;
  logic [c_PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [3:0]         r_starve_cnt, w_starve_cnt_nxt;
  logic [SEL_W-1:0]   r_lock_sel, w_lock_sel_nxt;

  logic               w_any_req;
  logic               w_valid;
  logic               w_xfer;
  logic               w_pick_max;
  logic               w_win_is_max;
  logic               w_lock_hold;
  logic [N_REQ-1:0]   w_rot;
  logic [N_REQ-1:0]   w_rot_1h;
  logic [N_REQ-1:0]   w_hold_vec;
  logic [c_PTR_W-1:0] w_enc [N_REQ+1];
  logic [c_PTR_W:0]   w_sum;
  logic [c_PTR_W-1:0] w_rr_station;
  logic [SEL_W-1:0]   w_rr_sel;
  logic [SEL_W-1:0]   w_open_sel;
  logic [SEL_W-1:0]   w_winner;

  assign w_any_req = |valid_i;
  assign w_valid   = (max_prio_valid_i | w_any_req) & ~flush_i;

  // Rotate requests so bit 0 is the station at rr_ptr, then take the lowest set bit.
  assign w_rot    = (valid_i >> r_rr_ptr)
                  | (valid_i << ((c_PTR_W+1)'(N_REQ) - {1'b0, r_rr_ptr}));
  assign w_rot_1h = w_rot & (~w_rot + N_REQ'(1));

  assign w_enc[0] = '0;
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_enc
    assign w_enc[gi+1] = w_enc[gi] | (w_rot_1h[gi] ? c_PTR_W'(gi) : '0);
  end

  assign w_sum        = {1'b0, r_rr_ptr} + {1'b0, w_enc[N_REQ]};
  assign w_rr_station = (w_sum >= (c_PTR_W+1)'(N_REQ))
                      ? c_PTR_W'(w_sum - (c_PTR_W+1)'(N_REQ))
                      : c_PTR_W'(w_sum);
  assign w_rr_sel     = SEL_W'(w_rr_station) + SEL_W'(1);

  assign w_pick_max   = max_prio_valid_i & ((r_starve_cnt < c_STARVE_MAX) | ~w_any_req);
  assign w_open_sel   = w_pick_max ? '0 : (w_any_req ? w_rr_sel : '0);
  assign w_winner     = (r_state == ST_LOCKED) ? r_lock_sel : w_open_sel;
  assign w_win_is_max = (w_winner == '0);

  // No transfer may complete while reset is asserted.
  assign w_xfer = w_valid & rob_ready_i & rst_n_i;

  assign rob_valid_o       = w_valid;
  assign served_o          = w_valid ? w_winner : '0;
  assign served_max_prio_o = w_valid & w_win_is_max;
  assign max_prio_ready_o  = w_xfer & w_win_is_max;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign ready_o[gi]    = w_xfer & (w_winner == SEL_W'(gi + 1));
    assign w_hold_vec[gi] = valid_i[gi] & (r_lock_sel == SEL_W'(gi + 1));
  end

  assign w_lock_hold = (r_lock_sel == '0) ? max_prio_valid_i : |w_hold_vec;

  always_comb begin
    w_state_nxt      = r_state;
    w_lock_sel_nxt   = r_lock_sel;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_starve_cnt_nxt = r_starve_cnt;

    case (r_state)
      ST_UNLOCKED: begin
        if (w_valid & ~rob_ready_i) begin
          w_state_nxt    = ST_LOCKED;
          w_lock_sel_nxt = w_winner;
        end
      end
      ST_LOCKED: begin
        if (w_xfer | flush_i) begin
          w_state_nxt = ST_UNLOCKED;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase

    if (w_xfer & ~w_win_is_max) begin
      w_rr_ptr_nxt = (w_winner == c_SEL_LAST) ? '0 : c_PTR_W'(w_winner);
    end

    if (~w_any_req) begin
      w_starve_cnt_nxt = '0;
    end else if (w_xfer) begin
      if (w_win_is_max) begin
        w_starve_cnt_nxt = (r_starve_cnt < c_STARVE_MAX) ? r_starve_cnt + 4'd1 : c_STARVE_MAX;
      end else begin
        w_starve_cnt_nxt = '0;
      end
    end

    if (flush_i) begin
      w_state_nxt      = ST_UNLOCKED;
      w_rr_ptr_nxt     = '0;
      w_starve_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_UNLOCKED;
      r_rr_ptr     <= '0;
      r_starve_cnt <= '0;
      r_lock_sel   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_lock_sel   <= w_lock_sel_nxt;
    end
  end

  // A locked requester must keep its valid asserted until it is accepted.
  property p_hold_while_locked;
    @(posedge clk_i) disable iff (!rst_n_i)
      (r_state == ST_LOCKED && !flush_i) |-> w_lock_hold;
  endproperty
  a_hold_while_locked: assert property (p_hold_while_locked);

endmodule
`default_nettype wire

// File: tb/tb_cdb_age_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cdb_age_arbiter
// Directed scenarios plus randomized traffic against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_cdb_age_arbiter;

  localparam int N_REQ      = 7;
  localparam int STARVE_MAX = 4;
  localparam int SEL_W      = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             mp_v;
  logic             rob_rdy;
  logic [N_REQ-1:0] v;
  logic             mp_rdy;
  logic             rob_vld;
  logic             srv_mp;
  logic [N_REQ-1:0] rdy;
  logic [SEL_W-1:0] srv;

  always #5 clk = ~clk;

  cdb_age_arbiter #(
    .N_REQ     (N_REQ),
    .STARVE_MAX(STARVE_MAX),
    .SEL_W     (SEL_W)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .flush_i          (flush),
    .max_prio_valid_i (mp_v),
    .max_prio_ready_o (mp_rdy),
    .valid_i          (v),
    .ready_o          (rdy),
    .rob_ready_i      (rob_rdy),
    .rob_valid_o      (rob_vld),
    .served_max_prio_o(srv_mp),
    .served_o         (srv)
  );

  typedef struct packed {
    logic             vld;
    logic             mp;
    logic [SEL_W-1:0] sel;
    logic             mp_rdy;
    logic [N_REQ-1:0] rdy;
  } out_t;

  out_t act;
  assign act = {rob_vld, srv_mp, srv, mp_rdy, rdy};

  int checks = 0;
  int errors = 0;

  // Reference state: next station to consider, age count, held winner.
  int m_rr       = 0;
  int m_starve   = 0;
  bit m_locked   = 1'b0;
  int m_lock_win = 0;

  function automatic int model_winner();
    if (m_locked) return m_lock_win;
    if (mp_v && (m_starve < STARVE_MAX || v == '0)) return 0;
    for (int off = 0; off < N_REQ; off++) begin
      int k;
      k = (m_rr + off) % N_REQ;
      if (((v >> k) & 7'd1) != 7'd0) return k + 1;
    end
    return 0;
  endfunction

  function automatic out_t model_out();
    out_t e;
    int   w;
    bit   xfer;
    e = '0;
    w = model_winner();
    e.vld = (mp_v || v != '0) && !flush;
    if (e.vld) begin
      e.sel = SEL_W'(w);
      e.mp  = (w == 0);
    end
    xfer = e.vld && rob_rdy && rst_n;
    if (xfer) begin
      if (w == 0) e.mp_rdy = 1'b1;
      else        e.rdy    = N_REQ'(1 << (w - 1));
    end
    return e;
  endfunction

  task automatic model_advance();
    out_t e;
    int   w;
    bit   xfer;
    e    = model_out();
    w    = model_winner();
    xfer = e.mp_rdy || (e.rdy != '0);
    if (!rst_n) begin
      m_rr = 0; m_starve = 0; m_locked = 1'b0; m_lock_win = 0;
    end else if (flush) begin
      m_rr = 0; m_starve = 0; m_locked = 1'b0;
    end else begin
      if (v == '0)               m_starve = 0;
      else if (xfer && w == 0)   m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else if (xfer)             m_starve = 0;
      if (xfer && w != 0)        m_rr = w % N_REQ;
      if (xfer)                  m_locked = 1'b0;
      else if (e.vld && !m_locked) begin
        m_locked   = 1'b1;
        m_lock_win = w;
      end
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e;
    rst_n = 1'b0; flush = 1'b0; mp_v = 1'b1; v = 7'b0100100; rob_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    e = model_out();
    checks++;
    if ({mp_rdy, rdy} !== 8'h00 || act !== e) begin
      errors++;
      $display("FAIL reset_ready act=%h exp=%h", act, e);
    end
    tick();
    rst_n = 1'b1; mp_v = 1'b0; v = '0;
    @(negedge clk);
    checks++;
    if (act !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_idle act=%h exp=0", act);
    end
    tick();
  endtask

  task automatic test_starvation();
    int   exp_sel [10] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 6};
    out_t e;
    mp_v = 1'b1; v = 7'b0100100; rob_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = model_out();
      checks++;
      if (srv !== SEL_W'(exp_sel[i]) || act !== e) begin
        errors++;
        $display("FAIL starve_cycle%0d served=%0d want=%0d act=%h exp=%h", i, srv, exp_sel[i], act, e);
      end
      tick();
    end
    mp_v = 1'b0; v = '0;
  endtask

  task automatic test_round_robin();
    int   exp_sel [6] = '{1, 4, 7, 1, 4, 7};
    out_t e;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== out_t'(0)) begin
      errors++;
      $display("FAIL rr_flush_idle act=%h exp=0", act);
    end
    tick();
    flush = 1'b0; v = 7'b1001001; rob_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = model_out();
      checks++;
      if (srv !== SEL_W'(exp_sel[i]) || rdy !== N_REQ'(1 << (exp_sel[i] - 1)) || act !== e) begin
        errors++;
        $display("FAIL rr_cycle%0d served=%0d ready=%b want=%0d act=%h exp=%h", i, srv, rdy, exp_sel[i], act, e);
      end
      tick();
    end
    v = '0;
  endtask

  task automatic test_lock_hold();
    out_t e;
    v = 7'b0010000; mp_v = 1'b0; rob_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) mp_v = 1'b1;
      @(negedge clk);
      e = model_out();
      checks++;
      if (srv !== 3'd5 || rdy !== '0 || mp_rdy !== 1'b0 || act !== e) begin
        errors++;
        $display("FAIL lock_hold%0d served=%0d ready=%b act=%h exp=%h", i, srv, rdy, act, e);
      end
      tick();
    end
    rob_rdy = 1'b1;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd5 || rdy !== 7'b0010000 || act !== e) begin
      errors++;
      $display("FAIL lock_release served=%0d ready=%b act=%h exp=%h", srv, rdy, act, e);
    end
    tick();
    v = '0;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd0 || mp_rdy !== 1'b1 || act !== e) begin
      errors++;
      $display("FAIL lock_then_max served=%0d mp_ready=%b act=%h exp=%h", srv, mp_rdy, act, e);
    end
    tick();
    mp_v = 1'b0;
  endtask

  task automatic test_flush_locked();
    out_t e;
    mp_v = 1'b0; v = 7'b0000010; rob_rdy = 1'b0;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd2 || act !== e) begin
      errors++;
      $display("FAIL flush_prelock served=%0d act=%h exp=%h", srv, act, e);
    end
    tick();
    flush = 1'b1; rob_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== out_t'(0)) begin
      errors++;
      $display("FAIL flush_cycle act=%h exp=0", act);
    end
    tick();
    flush = 1'b0; mp_v = 1'b1;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd0 || mp_rdy !== 1'b1 || act !== e) begin
      errors++;
      $display("FAIL flush_unlocked served=%0d act=%h exp=%h", srv, act, e);
    end
    tick();
    mp_v = 1'b0; v = 7'b1000010;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd2 || rdy !== 7'b0000010 || act !== e) begin
      errors++;
      $display("FAIL flush_rr_zero served=%0d ready=%b act=%h exp=%h", srv, rdy, act, e);
    end
    tick();
    v = '0;
  endtask

  task automatic test_max_only();
    out_t e;
    mp_v = 1'b1; v = '0; rob_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = model_out();
      checks++;
      if (srv_mp !== 1'b1 || mp_rdy !== 1'b1 || rdy !== '0 || act !== e) begin
        errors++;
        $display("FAIL max_only%0d act=%h exp=%h", i, act, e);
      end
      tick();
    end
    v = 7'b0001000;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd0 || mp_rdy !== 1'b1 || act !== e) begin
      errors++;
      $display("FAIL max_only_age served=%0d act=%h exp=%h", srv, act, e);
    end
    tick();
    mp_v = 1'b0;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd4 || rdy !== 7'b0001000 || act !== e) begin
      errors++;
      $display("FAIL max_only_station served=%0d act=%h exp=%h", srv, act, e);
    end
    tick();
    v = '0;
  endtask

  task automatic test_reset_mid_lock();
    out_t e;
    mp_v = 1'b0; v = 7'b0000100; rob_rdy = 1'b0;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd3 || act !== e) begin
      errors++;
      $display("FAIL rstlock_pre served=%0d act=%h exp=%h", srv, act, e);
    end
    tick();
    rst_n = 1'b0; mp_v = 1'b1; rob_rdy = 1'b1;
    @(negedge clk);
    e = model_out();
    checks++;
    if ({mp_rdy, rdy} !== 8'h00 || act !== e) begin
      errors++;
      $display("FAIL rstlock_no_xfer act=%h exp=%h", act, e);
    end
    tick();
    rst_n = 1'b1; v = 7'b0100100;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd0 || mp_rdy !== 1'b1 || act !== e) begin
      errors++;
      $display("FAIL rstlock_unlocked served=%0d act=%h exp=%h", srv, act, e);
    end
    tick();
    mp_v = 1'b0;
    @(negedge clk);
    e = model_out();
    checks++;
    if (srv !== 3'd3 || rdy !== 7'b0000100 || act !== e) begin
      errors++;
      $display("FAIL rstlock_rr_zero served=%0d act=%h exp=%h", srv, act, e);
    end
    tick();
    v = '0;
  endtask

  task automatic test_random();
    out_t             e;
    logic [N_REQ-1:0] nv;
    logic             nmp;
    rst_n = 1'b1; flush = 1'b0; mp_v = 1'b0; v = '0; rob_rdy = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e = model_out();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL random_cycle%0d act=%h exp=%h", c, act, e);
      end
      nv = v;
      for (int i = 0; i < N_REQ; i++) begin
        if (v[i]) begin
          if (e.rdy[i]) nv[i] = ($urandom_range(1) == 1);
        end else begin
          nv[i] = ($urandom_range(2) == 0);
        end
      end
      nmp = mp_v;
      if (mp_v) begin
        if (e.mp_rdy) nmp = ($urandom_range(1) == 1);
      end else begin
        nmp = ($urandom_range(2) == 0);
      end
      tick();
      v       = nv;
      mp_v    = nmp;
      flush   = ($urandom_range(15) == 0);
      rob_rdy = ($urandom_range(2) != 0);
      rst_n   = ($urandom_range(49) != 0);
    end
    rst_n = 1'b1; flush = 1'b0; mp_v = 1'b0; v = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_starvation();
    test_round_robin();
    test_lock_hold();
    test_flush_locked();
    test_max_only();
    test_reset_mid_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
